// File: rtl/bhg_packer_pkg.sv
// Shared types and lane-ordering helper for the narrow-to-wide FIFO packer.
// Lane order is reversed (MSB lane first) when BHG_PACKER_MSB_FIRST_EN is defined.
package bhg_packer_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_FLUSH = 1'b1
    } packer_state_t;

    // Map the running word count to the lane that word lands in.
    function automatic int unsigned lane_idx(input int unsigned cnt, input int unsigned ratio);
`ifdef BHG_PACKER_MSB_FIRST_EN
        lane_idx = (cnt < ratio) ? (ratio - 32'd1 - cnt) : 32'd0;
`else
        lane_idx = (cnt < ratio) ? cnt : 32'd0;
`endif
    endfunction

endpackage

// File: rtl/bhg_packer_timeout.sv
// Idle timer for the packer: counts idle cycles while a partial word is held
// and raises expire so the partial word is forced out.
module bhg_packer_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic accept,
    input  logic clear,
    output logic expire
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          pend_flush_q;
    logic          pend_flush_d;
    logic          hit_s;

    // Next timer / pending-flush state; a hit is visible the same cycle so the
    // flush request is not delayed behind the pend_flush flop.
    always_comb begin
        hit_s        = 1'b0;
        timer_d      = timer_q;
        pend_flush_d = pend_flush_q;
        if (TIMEOUT > 0) begin
            hit_s = active && !accept && (timer_q == TW'(TIMEOUT - 1));
        end else begin
            hit_s = 1'b0;
        end
        if (clear || accept) begin
            timer_d = {TW{1'b0}};
        end else if (active) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = timer_q;
        end
        if (clear) begin
            pend_flush_d = 1'b0;
        end else if (hit_s) begin
            pend_flush_d = 1'b1;
        end else begin
            pend_flush_d = pend_flush_q;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q      <= {TW{1'b0}};
            pend_flush_q <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            pend_flush_q <= pend_flush_d;
        end
    end

    assign expire = hit_s || pend_flush_q;

endmodule

// File: rtl/bhg_fifo_width_packer.sv
// Width-up converter: packs RATIO narrow FWFT words into one wide word with a
// per-lane valid mask. Optional macro BHG_PACKER_MSB_FIRST_EN reverses lane order.
module bhg_fifo_width_packer
    import bhg_packer_pkg::*;
#(
    parameter int BITS    = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_ready,
    input  logic [BITS-1:0]       in_data,
    output logic                  in_shift_out,
    input  logic                  flush,
    input  logic                  out_full,
    output logic                  out_shift_in,
    output logic [BITS*RATIO-1:0] out_data,
    output logic [RATIO-1:0]      out_mask,
    output logic                  busy
);

    localparam int CW = $clog2(RATIO);
    localparam int W  = BITS * RATIO;

    packer_state_t  state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   acc_q, acc_d, acc_w;
    logic [RATIO-1:0] mask_q, mask_d, mask_w;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic [RATIO-1:0] out_mask_q, out_mask_d;

    logic           slot_free_s;
    logic           last_s;
    logic           accept_s;
    logic           emit_s;
    logic           active_s;
    logic           expire_s;
    int unsigned    lane_s;

    // Handshake decode; kept apart from next-state so the timer's same-cycle
    // expire does not form a loop through one process.
    always_comb begin
        slot_free_s  = !out_valid_q || !out_full;
        out_shift_in = out_valid_q && !out_full;
        last_s       = (cnt_q == CW'(RATIO - 1));
        lane_s       = lane_idx(32'(cnt_q), unsigned'(RATIO));
        active_s     = (cnt_q != {CW{1'b0}}) && (state_q == ST_FILL);
        if (state_q == ST_FILL) begin
            in_shift_out = in_ready && (!last_s || slot_free_s);
        end else begin
            in_shift_out = 1'b0;
        end
        accept_s = in_shift_out;
    end

    bhg_packer_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .active (active_s),
        .accept (accept_s),
        .clear  (emit_s),
        .expire (expire_s)
    );

    // Accumulator write, word completion, flush FSM and output register load.
    always_comb begin
        acc_w       = acc_q;
        mask_w      = mask_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_mask_d  = out_mask_q;
        emit_s      = 1'b0;
        for (int i = 0; i < RATIO; i++) begin
            if (accept_s && (lane_s == unsigned'(i))) begin
                acc_w[i*BITS +: BITS] = in_data;
                mask_w[i]             = 1'b1;
            end
        end
        acc_d  = acc_w;
        mask_d = mask_w;
        if (out_shift_in) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        case (state_q)
            ST_FILL: begin
                if (accept_s && last_s) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_w;
                    out_mask_d  = {RATIO{1'b1}};
                    emit_s      = 1'b1;
                    cnt_d       = {CW{1'b0}};
                    acc_d       = {W{1'b0}};
                    mask_d      = {RATIO{1'b0}};
                end else if (accept_s) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                // Evaluated after the accept, so a flush that coincides with the
                // completing word is simply dropped.
                if ((flush || expire_s) && (cnt_d != {CW{1'b0}})) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_FLUSH: begin
                if (slot_free_s) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q;
                    out_mask_d  = mask_q;
                    emit_s      = 1'b1;
                    cnt_d       = {CW{1'b0}};
                    acc_d       = {W{1'b0}};
                    mask_d      = {RATIO{1'b0}};
                    state_d     = ST_FILL;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // Packer state and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FILL;
            cnt_q       <= {CW{1'b0}};
            acc_q       <= {W{1'b0}};
            mask_q      <= {RATIO{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {W{1'b0}};
            out_mask_q  <= {RATIO{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mask_q  <= out_mask_d;
        end
    end

    assign out_data = out_data_q;
    assign out_mask = out_mask_q;
    assign busy     = (cnt_q != {CW{1'b0}}) || out_valid_q || (state_q == ST_FLUSH);

endmodule

// File: tb/tb_bhg_fifo_width_packer.sv
// Directed self-checking bench for bhg_fifo_width_packer (BITS=8, RATIO=4, TIMEOUT=16).
// Expected words are written LSB-lane-first and mirrored when BHG_PACKER_MSB_FIRST_EN is set.
module tb_bhg_fifo_width_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_shift_out;
    logic        flush;
    logic        out_full;
    logic        out_shift_in;
    logic [31:0] out_data;
    logic [3:0]  out_mask;
    logic        busy;

    bhg_fifo_width_packer #(.BITS(8), .RATIO(4), .TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_shift_out (in_shift_out),
        .flush        (flush),
        .out_full     (out_full),
        .out_shift_in (out_shift_in),
        .out_data     (out_data),
        .out_mask     (out_mask),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    logic [7:0]  up_q[$];
    logic [31:0] got_data[$];
    logic [3:0]  got_mask[$];
    int          got_cyc[$];
    logic        up_en, drv_reset, drv_flush, drv_full;
    logic        obs_in_shift, obs_out_shift, obs_busy;
    logic [3:0]  obs_mask;
    logic [31:0] obs_data;
    int          cyc, pops, last_pop, base;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [31:0] lanes(input logic [31:0] w);
`ifdef BHG_PACKER_MSB_FIRST_EN
        lanes = {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        lanes = w;
`endif
    endfunction

    function automatic logic [3:0] lmask(input logic [3:0] m);
`ifdef BHG_PACKER_MSB_FIRST_EN
        lmask = {m[0], m[1], m[2], m[3]};
`else
        lmask = m;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, sample #1 later, model the FWFT pop at posedge.
    task automatic tick();
        @(negedge clk);
        reset    = drv_reset;
        flush    = drv_flush;
        out_full = drv_full;
        in_ready = up_en && (up_q.size() > 0);
        in_data  = (up_q.size() > 0) ? up_q[0] : 8'h00;
        #1;
        cyc++;
        obs_in_shift  = in_shift_out;
        obs_out_shift = out_shift_in;
        obs_busy      = busy;
        obs_mask      = out_mask;
        obs_data      = out_data;
        if (out_shift_in) begin
            got_data.push_back(out_data);
            got_mask.push_back(out_mask);
            got_cyc.push_back(cyc);
        end
        if (in_shift_out) begin
            pops++;
            last_pop = cyc;
        end
        @(posedge clk);
        if (obs_in_shift && (up_q.size() > 0)) void'(up_q.pop_front());
    endtask

    task automatic run_until(input int n, input int budget);
        int k = 0;
        while ((got_data.size() < n) && (k < budget)) begin
            tick();
            k++;
        end
    endtask

    task automatic clear_got();
        got_data.delete();
        got_mask.delete();
        got_cyc.delete();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_full = 1'b0; in_ready = 1'b0; in_data = 8'h00;
        up_en = 1'b0; drv_reset = 1'b1; drv_flush = 1'b0; drv_full = 1'b0;
        cyc = 0; pops = 0; last_pop = 0;

        repeat (2) tick();
        drv_reset = 1'b0;
        tick();
        check("rst_in_shift", obs_in_shift, 1'b0);
        check("rst_out_shift", obs_out_shift, 1'b0);
        check("rst_busy", obs_busy, 1'b0);
        check("rst_mask", obs_mask, 4'h0);
        check("rst_data", obs_data, 32'h0);

        // Streaming: push lands one cycle after the fourth accept.
        clear_got();
        up_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        up_en = 1'b1;
        run_until(1, 20);
        check("stream_cnt", got_data.size(), 1);
        check("stream_data", got_data[0], lanes(32'h44332211));
        check("stream_mask", got_mask[0], lmask(4'b1111));
        check("stream_lat", got_cyc[0] - last_pop, 1);
        repeat (3) tick();
        check("stream_once", got_data.size(), 1);
        check("stream_idle", obs_busy, 1'b0);

        // Explicit flush of a two-lane partial word.
        clear_got();
        up_q = '{8'hAA, 8'hBB};
        repeat (3) tick();
        drv_flush = 1'b1;
        tick();
        drv_flush = 1'b0;
        run_until(1, 10);
        check("flush_cnt", got_data.size(), 1);
        check("flush_data", got_data[0], lanes(32'h0000BBAA));
        check("flush_mask", got_mask[0], lmask(4'b0011));
        repeat (2) tick();
        check("flush_idle", obs_busy, 1'b0);

        // Flush with nothing accumulated: no empty word.
        clear_got();
        drv_flush = 1'b1;
        tick();
        drv_flush = 1'b0;
        repeat (6) tick();
        check("empty_flush_cnt", got_data.size(), 0);
        check("empty_flush_busy", obs_busy, 1'b0);

        // Timeout: 16 idle cycles after the accept, one cycle in ST_FLUSH to load
        // the output register, then the push is seen: 18 samples after the pop.
        clear_got();
        up_q = '{8'h5A};
        tick();
        check("tmo_pop", last_pop, cyc);
        run_until(1, 40);
        check("tmo_cnt", got_data.size(), 1);
        check("tmo_data", got_data[0], lanes(32'h0000005A));
        check("tmo_mask", got_mask[0], lmask(4'b0001));
        check("tmo_lat", got_cyc[0] - last_pop, 18);

        // Backpressure: first word parks in the output register, second stalls at lane 3.
        clear_got();
        base = pops;
        drv_full = 1'b1;
        up_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        repeat (12) tick();
        check("bp_pops", pops - base, 7);
        check("bp_stall", obs_in_shift, 1'b0);
        check("bp_nopush", got_data.size(), 0);
        check("bp_busy", obs_busy, 1'b1);
        drv_full = 1'b0;
        run_until(2, 20);
        repeat (3) tick();
        check("bp_cnt", got_data.size(), 2);
        check("bp_word0", got_data[0], lanes(32'h44332211));
        check("bp_word1", got_data[1], lanes(32'h88776655));
        check("bp_pops_all", pops - base, 8);

        // Reset mid-fill with an output word pending.
        clear_got();
        base = pops;
        drv_full = 1'b1;
        up_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        repeat (8) tick();
        check("rmid_pops", pops - base, 6);
        check("rmid_busy", obs_busy, 1'b1);
        up_en = 1'b0;
        drv_reset = 1'b1;
        tick();
        drv_reset = 1'b0;
        drv_full = 1'b0;
        tick();
        check("rmid_out_shift", obs_out_shift, 1'b0);
        check("rmid_busy0", obs_busy, 1'b0);
        check("rmid_mask", obs_mask, 4'h0);
        clear_got();
        up_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        up_en = 1'b1;
        run_until(1, 20);
        check("rmid_cnt", got_data.size(), 1);
        check("rmid_data", got_data[0], lanes(32'hD4C3B2A1));

        // Single-lane partial word: top lane when MSB-first is built in.
        clear_got();
        up_q = '{8'h11};
        tick();
        drv_flush = 1'b1;
        tick();
        drv_flush = 1'b0;
        run_until(1, 10);
        check("one_cnt", got_data.size(), 1);
        check("one_data", got_data[0], lanes(32'h00000011));
        check("one_mask", got_mask[0], lmask(4'b0001));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
